// File: rtl/seg_scan_controller.sv
// Four-digit common-anode seven-segment scan controller with dead-time blanking,
// PWM brightness, leading-zero blanking and a frame-synchronous double buffer.
module seg_scan_controller #(
  parameter int SLOT_CYCLES  = 12500,
  parameter int BLANK_CYCLES = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_bcd,
  input  logic [3:0]  load_dp,
  input  logic [3:0]  digit_en,
  input  logic        lzb,
  input  logic [2:0]  bright,
  output logic [3:0]  an,
  output logic [6:0]  segment,
  output logic        dp,
  output logic        frame_done
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [31:0] BLANK_W = 32'(BLANK_CYCLES);
  localparam logic [31:0] ON_SPAN = 32'(SLOT_CYCLES - BLANK_CYCLES);

  logic [CW-1:0] slot_cnt;
  logic [1:0]    digit;
  logic [3:0]    en_s;
  logic          lzb_s;
  logic [2:0]    bright_s;
  logic [15:0]   active_bcd;
  logic [3:0]    active_dp;
  logic [15:0]   shadow_bcd;
  logic [3:0]    shadow_dp;
  logic          pending;

  logic          slot_start;
  logic          slot_end;
  logic          frame_end;
  logic [31:0]   on_len;
  logic [31:0]   slot_ext;
  logic          in_window;
  logic [3:0]    nib;
  logic          upper_zero;
  logic          blank_digit;
  logic          show;
  logic [6:0]    seg_dec;

  assign slot_start = (slot_cnt == '0);
  assign slot_end   = (slot_cnt == SLOT_LAST);
  assign frame_end  = slot_end && (digit == 2'd3);
  assign load_ready = ~pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt <= '0;
      digit    <= 2'd0;
    end else if (slot_end) begin
      slot_cnt <= '0;
      digit    <= digit + 2'd1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // Controls are latched once per slot so a slot never changes shape midway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_s     <= 4'b1111;
      lzb_s    <= 1'b0;
      bright_s <= 3'd7;
    end else if (slot_start) begin
      en_s     <= digit_en;
      lzb_s    <= lzb;
      bright_s <= bright;
    end
  end

  // Commit and accept are exclusive: commit needs pending, accept needs it clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_bcd <= 16'h0000;
      active_dp  <= 4'b0000;
      shadow_bcd <= 16'h0000;
      shadow_dp  <= 4'b0000;
      pending    <= 1'b0;
    end else if (frame_end && pending) begin
      active_bcd <= shadow_bcd;
      active_dp  <= shadow_dp;
      pending    <= 1'b0;
    end else if (load_valid && !pending) begin
      shadow_bcd <= load_bcd;
      shadow_dp  <= load_dp;
      pending    <= 1'b1;
    end
  end

  always_comb begin
    on_len    = (ON_SPAN * (32'(bright_s) + 32'd1)) >> 3;
    slot_ext  = 32'(slot_cnt);
    in_window = (slot_ext >= BLANK_W) && (slot_ext < (BLANK_W + on_len));
    nib       = active_bcd[{digit, 2'b00} +: 4];
  end

  // A digit is a leading zero when it and everything to its left is zero.
  always_comb begin
    upper_zero = 1'b0;
    case (digit)
      2'd3:    upper_zero = (active_bcd[15:12] == 4'h0);
      2'd2:    upper_zero = (active_bcd[15:8] == 8'h00);
      2'd1:    upper_zero = (active_bcd[15:4] == 12'h000);
      default: upper_zero = 1'b0;
    endcase
    blank_digit = !en_s[digit] || (nib > 4'd9) || (lzb_s && upper_zero);
    show        = in_window && !blank_digit;
  end

  always_comb begin
    seg_dec = 7'b1111111;
    case (nib)
      4'd0:    seg_dec = 7'b1000000;
      4'd1:    seg_dec = 7'b1111001;
      4'd2:    seg_dec = 7'b0100100;
      4'd3:    seg_dec = 7'b0110000;
      4'd4:    seg_dec = 7'b0011001;
      4'd5:    seg_dec = 7'b0010010;
      4'd6:    seg_dec = 7'b0000010;
      4'd7:    seg_dec = 7'b1111000;
      4'd8:    seg_dec = 7'b0000000;
      4'd9:    seg_dec = 7'b0010000;
      default: seg_dec = 7'b1111111;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= 4'b1111;
      segment    <= 7'b1111111;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (show) begin
        an      <= ~(4'b0001 << digit);
        segment <= seg_dec;
        dp      <= ~active_dp[digit];
      end else begin
        an      <= 4'b1111;
        segment <= 7'b1111111;
        dp      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Scoreboard bench for seg_scan_controller: a cycle-position reference model queues
// the expected pin state after every clock edge and a negedge monitor compares it.
module tb_seg_scan_controller;

  localparam int SLOT  = 16;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * SLOT;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_bcd;
  logic [3:0]  load_dp;
  logic [3:0]  digit_en;
  logic        lzb;
  logic [2:0]  bright;
  logic [3:0]  an;
  logic [6:0]  segment;
  logic        dp;
  logic        frame_done;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   done = 0;

  seg_scan_controller #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_bcd(load_bcd), .load_dp(load_dp), .digit_en(digit_en), .lzb(lzb),
    .bright(bright), .an(an), .segment(segment), .dp(dp), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
    end
  endtask

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Reference model: everything is derived from the edge count since reset.
  initial begin
    int p, pos, d, on_len, val, word;
    logic [15:0] shown, held;
    logic [3:0] shown_dp, held_dp, en_m, one_hot;
    bit have_held, lzb_m, lit, dark;
    int bright_m;
    exp_t e;
    p = 0; shown = 0; shown_dp = 0; held = 0; held_dp = 0; have_held = 0;
    en_m = 4'b1111; lzb_m = 0; bright_m = 7;
    forever begin
      @(posedge clk);
      if (rst) begin
        p = 0; shown = 0; shown_dp = 0; have_held = 0;
        en_m = 4'b1111; lzb_m = 0; bright_m = 7;
        exp_q.delete();
      end else begin
        pos = p % SLOT;
        d = (p / SLOT) % 4;
        if (pos == 0) begin
          en_m = digit_en; lzb_m = lzb; bright_m = int'(bright);
        end
        on_len = ((SLOT - BLANK) * (bright_m + 1)) / 8;
        lit = (pos >= BLANK) && (pos < BLANK + on_len);
        word = int'(shown);
        val = (word >> (4 * d)) % 16;
        dark = !en_m[d] || (val > 9) || (lzb_m && d >= 1 && (word >> (4 * d)) == 0);
        one_hot = 4'b0001 << d;
        if (lit && !dark) begin
          e.an = ~one_hot; e.seg = seg_of(val); e.dp = ~shown_dp[d];
        end else begin
          e.an = 4'b1111; e.seg = 7'b1111111; e.dp = 1'b1;
        end
        e.fd = (p % FRAME == FRAME - 1);
        if (e.fd && have_held) begin
          shown = held; shown_dp = held_dp; have_held = 0;
        end else if (load_valid && !have_held) begin
          held = load_bcd; held_dp = load_dp; have_held = 1;
        end
        e.rdy = !have_held;
        exp_q.push_back(e);
        p++;
      end
    end
  end

  // Monitor: with nothing queued the DUT must be sitting in its reset state.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!done) begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1, fd: 1'b0, rdy: 1'b1};
        checkOutput("an", 32'(an), 32'(e.an));
        checkOutput("segment", 32'(segment), 32'(e.seg));
        checkOutput("dp", 32'(dp), 32'(e.dp));
        checkOutput("frame_done", 32'(frame_done), 32'(e.fd));
        checkOutput("load_ready", 32'(load_ready), 32'(e.rdy));
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Producer that holds the word until the handshake completes.
  task automatic applyStimulus(input logic [15:0] w, input logic [3:0] d);
    int n;
    logic r;
    load_bcd = w; load_dp = d; load_valid = 1'b1;
    n = 0; r = 1'b0;
    while (!r && n < 300) begin
      @(negedge clk);
      r = load_ready;
      @(posedge clk);
      #1;
      n++;
    end
    load_valid = 1'b0;
    checkOutput("accept", 32'(r), 32'd1);
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 9) < 4) w[i*4 +: 4] = 4'h0;
      else w[i*4 +: 4] = 4'($urandom_range(0, 15));
    end
    return w;
  endfunction

  initial begin
    rst = 1'b1; load_valid = 1'b0; load_bcd = 16'h0; load_dp = 4'h0;
    digit_en = 4'b1111; lzb = 1'b0; bright = 3'd7;
    waitCycles(4);
    rst = 1'b0;
    waitCycles(2 * FRAME);

    applyStimulus(16'h1234, 4'b0100);
    applyStimulus(16'h9999, 4'b0000);
    waitCycles(2 * FRAME);

    bright = 3'd0;
    waitCycles(FRAME + 5);
    bright = 3'd3;
    waitCycles(FRAME + 7);
    bright = 3'd7;
    waitCycles(FRAME);

    applyStimulus(16'h0050, 4'b0000);
    lzb = 1'b1;
    waitCycles(2 * FRAME + 10);
    applyStimulus(16'h0000, 4'b1111);
    waitCycles(2 * FRAME + 10);

    lzb = 1'b0;
    digit_en = 4'b1010;
    applyStimulus(16'h5C38, 4'b1001);
    waitCycles(2 * FRAME);
    digit_en = 4'b1111;
    waitCycles(2 * FRAME);

    applyStimulus(16'h4321, 4'b0011);
    waitCycles(9);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_an", 32'(an), 32'h0000000F);
    checkOutput("rst_segment", 32'(segment), 32'h0000007F);
    checkOutput("rst_dp", 32'(dp), 32'd1);
    checkOutput("rst_ready", 32'(load_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    waitCycles(FRAME);

    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 4))
        0: digit_en = 4'($urandom_range(0, 15));
        1: lzb = 1'($urandom_range(0, 1));
        2: bright = 3'($urandom_range(0, 7));
        3: applyStimulus(rand_word(), 4'($urandom_range(0, 15)));
        default: begin
          load_bcd = rand_word(); load_dp = 4'($urandom_range(0, 15));
          load_valid = 1'b1;
          waitCycles($urandom_range(1, 3));
          load_valid = 1'b0;
        end
      endcase
      waitCycles($urandom_range(1, 40));
    end
    waitCycles(2 * FRAME);

    done = 1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
